// File: rtl/m14k_tagram_pkg.sv
// Shared types and helpers for the m14k tag RAM with hardware cache init.
// Build option: define M14K_TAGRAM_PARITY_EN to store one even-parity bit per way.
package m14k_tagram_pkg;

  // Sequencer states; encoding is fixed so it can be matched in debug views.
  typedef enum logic [1:0] {
    StInit = 2'd0,
    StDone = 2'd1,
    StIdle = 2'd2
  } hci_state_e;

  // Widest tag word the parity helper accepts.
  localparam int unsigned TagMax = 64;

  typedef logic [TagMax-1:0] tag_way_t;

`ifdef M14K_TAGRAM_PARITY_EN
  localparam int unsigned ParBits = 1;
`else
  localparam int unsigned ParBits = 0;
`endif

  // Stored bits per way: tag word plus optional parity bit.
  function automatic int unsigned way_bits(int unsigned tag_width);
    return tag_width + ParBits;
  endfunction

  // Even parity over a zero-extended tag word.
  function automatic logic tag_parity(tag_way_t d);
    return ^d;
  endfunction

endpackage

// File: rtl/m14k_tagram_array.sv
// Behavioural per-way tag storage: one bank per way, shared address, per-way
// write enable and a registered read port. Swap this file for a vendor SRAM.
module m14k_tagram_array #(
  parameter int unsigned Ways  = 4,
  parameter int unsigned IdxW  = 7,
  parameter int unsigned WordW = 24
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  re,
  input  logic                  we,
  input  logic [IdxW-1:0]       addr,
  input  logic [Ways-1:0]       wmask,
  input  logic [Ways*WordW-1:0] wdata,
  output logic [Ways*WordW-1:0] rdata
);

  localparam int unsigned Depth = 1 << IdxW;

  for (genvar w = 0; w < Ways; w++) begin : g_way
    logic [WordW-1:0] mem [Depth];
    logic [WordW-1:0] rd_q;

    // Masked write into this way's bank; contents are never reset.
    always_ff @(posedge clk) begin
      if (we && wmask[w]) begin
        mem[addr] <= wdata[w*WordW +: WordW];
      end
    end

    // Registered read; holds while re is low, reads old data on same-index write.
    always_ff @(posedge clk) begin
      if (clr) begin
        rd_q <= '0;
      end else if (re) begin
        rd_q <= mem[addr];
      end
    end

    assign rdata[w*WordW +: WordW] = rd_q;
  end

endmodule

// File: rtl/m14k_tagram_hwinit.sv
// Cache tag RAM wrapper with hardware cache-init sequencer. After reset or an
// init request, every line is swept to zero while hci stalls the controllers.
// Build option: M14K_TAGRAM_PARITY_EN adds per-way parity storage and par_err.
module m14k_tagram_hwinit
  import m14k_tagram_pkg::*;
#(
  parameter int unsigned ASSOC         = 4,
  parameter int unsigned LINE_IDX_SIZE = 7,
  parameter int unsigned TAG_WIDTH     = 24
) (
  input  logic                       clk,
  input  logic                       greset,
  input  logic [LINE_IDX_SIZE-1:0]   line_idx,
  input  logic [ASSOC-1:0]           wr_mask,
  input  logic                       rd_str,
  input  logic                       wr_str,
  input  logic [TAG_WIDTH-1:0]       wr_data,
  input  logic                       init_req,
  output logic [ASSOC*TAG_WIDTH-1:0] rd_data,
  output logic                       hci,
  output logic                       init_done,
  output logic [ASSOC-1:0]           par_err
);

  localparam int unsigned WayW = way_bits(TAG_WIDTH);

  hci_state_e               state_q, state_d;
  logic [LINE_IDX_SIZE-1:0] cnt_q, cnt_d;

  logic                     arr_re, arr_we, arr_clr;
  logic [LINE_IDX_SIZE-1:0] arr_addr;
  logic [ASSOC-1:0]         arr_mask;
  logic [WayW-1:0]          way_word;
  logic [ASSOC*WayW-1:0]    arr_wdata, arr_rdata;

  // Sequencer state and sweep counter.
  always_ff @(posedge clk) begin
    if (greset) begin
      state_q <= StInit;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, array port steering and status outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hci       = 1'b0;
    init_done = 1'b0;
    arr_re    = 1'b0;
    arr_we    = 1'b0;
    arr_addr  = line_idx;
    arr_mask  = wr_mask;
    way_word  = '0;
    case (state_q)
      StInit: begin
        hci      = 1'b1;
        arr_we   = 1'b1;
        arr_addr = cnt_q;
        arr_mask = '1;
        cnt_d    = cnt_q + 1'b1;
        if (&cnt_q) begin
          state_d = StDone;
        end
      end
      StDone: begin
        init_done = 1'b1;
        cnt_d     = '0;
        state_d   = StIdle;
      end
      StIdle: begin
        arr_re = rd_str;
        arr_we = wr_str;
`ifdef M14K_TAGRAM_PARITY_EN
        way_word = {tag_parity(tag_way_t'(wr_data)), wr_data};
`else
        way_word = wr_data;
`endif
        // The access in this cycle still completes; the sweep starts after it.
        if (init_req) begin
          state_d = StInit;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StInit;
        cnt_d   = '0;
      end
    endcase
    // A reset cycle never disturbs the array; the following sweep owns it.
    if (greset) begin
      arr_we = 1'b0;
    end
  end

  // Read register is held at zero for the whole sweep.
  assign arr_clr   = greset | (state_q == StInit);
  assign arr_wdata = {ASSOC{way_word}};

  m14k_tagram_array #(
    .Ways  (ASSOC),
    .IdxW  (LINE_IDX_SIZE),
    .WordW (WayW)
  ) u_array (
    .clk   (clk),
    .clr   (arr_clr),
    .re    (arr_re),
    .we    (arr_we),
    .addr  (arr_addr),
    .wmask (arr_mask),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

  for (genvar w = 0; w < ASSOC; w++) begin : g_out
    assign rd_data[w*TAG_WIDTH +: TAG_WIDTH] = arr_rdata[w*WayW +: TAG_WIDTH];
`ifdef M14K_TAGRAM_PARITY_EN
    assign par_err[w] = arr_rdata[w*WayW + TAG_WIDTH]
                      ^ tag_parity(tag_way_t'(arr_rdata[w*WayW +: TAG_WIDTH]));
`else
    assign par_err[w] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_m14k_tagram_hwinit.sv
// Scoreboard bench for m14k_tagram_hwinit: reads are predicted from a simple
// array model and checked by an independent monitor one cycle after rd_str.
module tb_m14k_tagram_hwinit;

  localparam int unsigned ASSOC = 4;
  localparam int unsigned LIS   = 7;
  localparam int unsigned TW    = 24;
  localparam int unsigned DEPTH = 1 << LIS;
`ifdef M14K_TAGRAM_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  greset = 1'b1;
  logic [LIS-1:0]        line_idx = '0;
  logic [ASSOC-1:0]      wr_mask = '0;
  logic                  rd_str = 1'b0;
  logic                  wr_str = 1'b0;
  logic [TW-1:0]         wr_data = '0;
  logic                  init_req = 1'b0;
  logic [ASSOC*TW-1:0]   rd_data;
  logic                  hci;
  logic                  init_done;
  logic [ASSOC-1:0]      par_err;

  always #5 clk = ~clk;

  m14k_tagram_hwinit #(
    .ASSOC         (ASSOC),
    .LINE_IDX_SIZE (LIS),
    .TAG_WIDTH     (TW)
  ) dut (
    .clk       (clk),
    .greset    (greset),
    .line_idx  (line_idx),
    .wr_mask   (wr_mask),
    .rd_str    (rd_str),
    .wr_str    (wr_str),
    .wr_data   (wr_data),
    .init_req  (init_req),
    .rd_data   (rd_data),
    .hci       (hci),
    .init_done (init_done),
    .par_err   (par_err)
  );

  typedef struct packed {
    logic [ASSOC*TW-1:0] data;
    logic [ASSOC-1:0]    perr;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic rd_issue = 1'b0;

  // Reference model: stored tag per way and the parity recorded at write time.
  logic [TW-1:0] m_data [DEPTH][ASSOC];
  logic          m_par  [DEPTH][ASSOC];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      for (int w = 0; w < ASSOC; w++) begin
        m_data[i][w] = '0;
        m_par[i][w]  = 1'b0;
      end
    end
  endfunction

  function automatic exp_t model_read(input int idx);
    exp_t e;
    e = '0;
    for (int w = 0; w < ASSOC; w++) begin
      e.data[w*TW +: TW] = m_data[idx][w];
      e.perr[w]          = PAR_EN & (m_par[idx][w] ^ (^m_data[idx][w]));
    end
    return e;
  endfunction

  function automatic void model_write(input int idx, input logic [ASSOC-1:0] mask,
                                      input logic [TW-1:0] d);
    for (int w = 0; w < ASSOC; w++) begin
      if (mask[w]) begin
        m_data[idx][w] = d;
        m_par[idx][w]  = ^d;
      end
    end
  endfunction

  // One IDLE-mode bus cycle; the expected read (old contents) is queued first.
  task automatic cycle(input bit rd, input bit wr, input bit ir, input int idx,
                       input logic [ASSOC-1:0] mask, input logic [TW-1:0] d);
    @(negedge clk);
    rd_str   = rd;
    wr_str   = wr;
    init_req = ir;
    line_idx = idx[LIS-1:0];
    wr_mask  = mask;
    wr_data  = d;
    rd_issue = rd;
    if (rd) exp_q.push_back(model_read(idx));
    if (wr) model_write(idx, mask, d);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 1'b0, 0, '0, '0);
  endtask

  // Called on the first negedge of a sweep; returns on the first IDLE negedge.
  task automatic check_sweep();
    int n;
    bit done_early;
    bit rd_bad;
    n = 0;
    done_early = 1'b0;
    rd_bad = 1'b0;
    while (hci === 1'b1 && n < 1000) begin
      if (init_done !== 1'b0) done_early = 1'b1;
      if (n > 0 && (rd_data !== '0 || par_err !== '0)) rd_bad = 1'b1;
      n++;
      @(negedge clk);
    end
    check("hci_cycles", n, 128);
    check("init_done_pulse", init_done, 1);
    check("init_done_early", done_early, 0);
    check("rd_zero_in_init", rd_bad, 0);
    @(negedge clk);
    check("init_done_low", init_done, 0);
    check("hci_low", hci, 0);
  endtask

  // Monitor: a read issued before this edge must be presented right after it.
  initial begin
    logic v;
    exp_t e;
    forever begin
      @(posedge clk);
      v = rd_issue;
      #1;
      if (v) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL sb_underflow: got read with empty queue at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          check("rd_data", rd_data, e.data);
          check("par_err", par_err, e.perr);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [TW-1:0] d;
    model_clear();
    repeat (3) @(negedge clk);
    check("rst_hci", hci, 1);
    check("rst_init_done", init_done, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_par_err", par_err, 0);
    greset = 1'b0;
    check_sweep();

    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 1'b0, i, '0, '0);
    idle();

    // Masked write then read, and hold while rd_str is low.
    cycle(1'b0, 1'b1, 1'b0, 5, 4'b0101, 24'hABCDEF);
    cycle(1'b1, 1'b0, 1'b0, 5, '0, '0);
    idle();
    idle();
    check("rd_hold", rd_data, {24'h0, 24'hABCDEF, 24'h0, 24'hABCDEF});

    // Read-before-write on the same index.
    cycle(1'b1, 1'b1, 1'b0, 9, 4'hF, 24'h111111);
    cycle(1'b1, 1'b0, 1'b0, 9, '0, '0);
    idle();

    // Reset mid-sweep; accesses during the sweep are ignored.
    @(negedge clk);
    greset = 1'b1;
    @(negedge clk);
    greset = 1'b0;
    model_clear();
    for (int i = 0; i < 60; i++) begin
      if (i == 10) begin
        rd_str = 1'b1; wr_str = 1'b1; line_idx = 7'd2; wr_mask = 4'hF; wr_data = 24'h5A5A5A;
      end else begin
        rd_str = 1'b0; wr_str = 1'b0;
      end
      if (i == 12) check("rd_ignored_in_init", rd_data, 0);
      @(negedge clk);
    end
    check("hci_at_cnt60", hci, 1);
    greset = 1'b1;
    @(negedge clk);
    greset = 1'b0;
    check_sweep();
    cycle(1'b1, 1'b0, 1'b0, 2, '0, '0);
    cycle(1'b1, 1'b0, 1'b0, 5, '0, '0);

    // Randomised traffic over a small index window to force reuse.
    repeat (400) begin
      cycle(1'($urandom), 1'($urandom), 1'b0, int'($urandom_range(0, 15)),
            ASSOC'($urandom), TW'($urandom));
    end
    idle();

    // Init request alongside an access: the access completes, then the sweep.
    d = TW'($urandom);
    cycle(1'b0, 1'b1, 1'b0, 3, 4'hF, d);
    cycle(1'b1, 1'b0, 1'b0, 3, '0, '0);
    cycle(1'b1, 1'b1, 1'b1, 3, 4'hF, ~d);
    idle();
    model_clear();
    check_sweep();
    cycle(1'b1, 1'b0, 1'b0, 3, '0, '0);
    cycle(1'b1, 1'b0, 1'b0, 5, '0, '0);

    // Corrupt one stored bit of way 1 at index 7, then read it back.
    d = TW'($urandom);
    cycle(1'b0, 1'b1, 1'b0, 7, 4'hF, d);
    idle();
    dut.u_array.g_way[1].mem[7][3] <= ~dut.u_array.g_way[1].mem[7][3];
    m_data[7][1] = m_data[7][1] ^ 24'h000008;
    cycle(1'b1, 1'b0, 1'b0, 7, '0, '0);
    cycle(1'b0, 1'b1, 1'b0, 7, 4'b0010, ~d);
    cycle(1'b1, 1'b0, 1'b0, 7, '0, '0);

    repeat (3) idle();
    check("sb_drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
